egg_timer_display: RTL and testbench

EGG_TIMER_DISPLAY -- requirements
Module: egg_timer_display

---
 rtl/egg_timer_display.sv | 186 ++++++++++++++++++
 tb/tb_egg_timer_display.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egg_timer_display.sv
// egg_timer_display: four-digit multiplexed seven-segment driver for an MM:SS egg timer.
// The digits are scanned s_ones -> s_tens -> m_ones -> m_tens, and each one is lit for
// SCAN_DIV clocks. A snapshot of the inputs is taken once per frame, so a frame never
// shows a mix of old and new digits. The display blinks while the alarm is up, and the
// colon (dp on m_ones) blinks while the timer runs.
// Optional build macro: EGG_DISP_LZB_EN enables leading-zero blanking of the m_tens digit.
module egg_timer_display #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] m_tens,
    input  logic [3:0] m_ones,
    input  logic [2:0] s_tens,
    input  logic [3:0] s_ones,
    input  logic       timer_on,
    input  logic       alarm,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Scan order is simply increment-and-wrap, so 3 -> 0 closes a frame.
    typedef enum logic [1:0] {
        IDX_S_ONES = 2'd0,
        IDX_S_TENS = 2'd1,
        IDX_M_ONES = 2'd2,
        IDX_M_TENS = 2'd3
    } digit_idx_t;

    typedef struct packed {
        logic [2:0] m_tens;
        logic [3:0] m_ones;
        logic [2:0] s_tens;
        logic [3:0] s_ones;
    } digits_t;

    // Active-low {g,f,e,d,c,b,a}. Out-of-range values show a dash. Tens digits cap at 5.
    function automatic logic [6:0] seg_decode(input logic [3:0] value, input logic is_tens);
        logic [6:0] pattern;
        if (is_tens && value > 4'd5) begin
            pattern = SEG_DASH;
        end else begin
            case (value)
                4'd0:    pattern = 7'b1000000;
                4'd1:    pattern = 7'b1111001;
                4'd2:    pattern = 7'b0100100;
                4'd3:    pattern = 7'b0110000;
                4'd4:    pattern = 7'b0011001;
                4'd5:    pattern = 7'b0010010;
                4'd6:    pattern = 7'b0000010;
                4'd7:    pattern = 7'b1111000;
                4'd8:    pattern = 7'b0000000;
                4'd9:    pattern = 7'b0010000;
                default: pattern = SEG_DASH;
            endcase
        end
        return pattern;
    endfunction

    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    digit_idx_t         idx_q,   idx_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               blink_q, blink_d;
    digits_t            snap_q,  snap_d;
    logic [3:0]         an_q,    an_d;
    logic [6:0]         seg_q,   seg_d;
    logic               dp_q,    dp_d;

    logic               advance;
    digits_t            live;
    logic [3:0]         digit_val;
    logic               digit_is_tens;

    assign live = {m_tens, m_ones, s_tens, s_ones};

    // Scan timing, digit index, frame/blink counting and the per-frame input snapshot.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through this block can infer a latch.
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        frame_d = frame_q;
        blink_d = blink_q;
        snap_d  = snap_q;
        advance = (cnt_q == CNT_LAST);
        if (advance) begin
            cnt_d = '0;
            idx_d = digit_idx_t'(idx_q + 2'd1);
            if (idx_q == IDX_M_TENS) begin
                // Start of a new frame: take a fresh snapshot and count the frame.
                snap_d = live;
                if (frame_q == FRAME_LAST) begin
                    frame_d = '0;
                    blink_d = ~blink_q;
                end else begin
                    frame_d = frame_q + 1'b1;
                end
            end
        end
    end

    // Select the digit that is lit at the next advance edge.
    // snap_d holds the live inputs at the capture edge and holds the snapshot at all other edges.
    always_comb begin
        digit_val     = snap_d.s_ones;
        digit_is_tens = 1'b0;
        case (idx_d)
            IDX_S_ONES: digit_val = snap_d.s_ones;
            IDX_S_TENS: begin
                digit_val     = {1'b0, snap_d.s_tens};
                digit_is_tens = 1'b1;
            end
            IDX_M_ONES: digit_val = snap_d.m_ones;
            IDX_M_TENS: begin
                digit_val     = {1'b0, snap_d.m_tens};
                digit_is_tens = 1'b1;
            end
        endcase
    end

    // Compute the next registered anode, segment and dp values. They change only at advance edges.
    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        if (advance) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = seg_decode(digit_val, digit_is_tens);
`ifdef EGG_DISP_LZB_EN
            // A leading zero in the minutes is blanked. The anode is still driven.
            if (idx_d == IDX_M_TENS && snap_d.m_tens == 3'd0) begin
                seg_d = SEG_OFF;
            end
`endif
            // The colon sits on m_ones. It is steady while idle and blinks while counting.
            dp_d = 1'b1;
            if (idx_d == IDX_M_ONES) begin
                dp_d = timer_on ? blink_d : 1'b0;
            end
            // The alarm blink has priority and also blanks the colon.
            if (alarm && blink_d) begin
                an_d = 4'b1111;
                dp_d = 1'b1;
            end
        end
    end

    // State registers. Reset leaves the display dark, parked just before digit 0.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only; the snapshot is reset as well.
        if (!reset) begin
            cnt_q   <= '0;
            idx_q   <= IDX_M_TENS;
            frame_q <= '0;
            blink_q <= 1'b0;
            snap_q  <= '0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_egg_timer_display.sv
// tb_egg_timer_display: directed bench for egg_timer_display with SCAN_DIV=4, BLINK_FRAMES=2.
// The frame number counts the 3->0 advances since reset release. In frame k the blink phase
// equals (k/2)%2. The expected tables below are hand-written for those frames.
module tb_egg_timer_display;

    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
`ifdef EGG_DISP_LZB_EN
    localparam logic [6:0] SEG_MT0  = SEG_OFF;
`else
    localparam logic [6:0] SEG_MT0  = SEG_0;
`endif

    localparam logic [3:0] AN_IDX [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic       clk;
    logic       reset;
    logic [2:0] m_tens;
    logic [3:0] m_ones;
    logic [2:0] s_tens;
    logic [3:0] s_ones;
    logic       timer_on;
    logic       alarm;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_pass   = 0;
    int frame_no = 0;

    logic [3:0] obs_an  [4];
    logic [6:0] obs_seg [4];
    logic       obs_dp  [4];

    egg_timer_display #(
        .SCAN_DIV    (SCAN_DIV),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m_tens  (m_tens),
        .m_ones  (m_ones),
        .s_tens  (s_tens),
        .s_ones  (s_ones),
        .timer_on(timer_on),
        .alarm   (alarm),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Record one whole frame, starting at index 0 just after its advance edge.
    task automatic grab_frame();
        for (int d = 0; d < 4; d++) begin
            obs_an[d]  = an;
            obs_seg[d] = seg;
            obs_dp[d]  = dp;
            step(SCAN_DIV);
        end
        frame_no++;
    endtask

    task automatic test_reset();
        logic [6:0] exp_seg [4];
        logic       exp_dp;
        exp_seg = '{SEG_4, SEG_3, SEG_2, SEG_1};
        reset = 1'b1; m_tens = 3'd1; m_ones = 4'd2; s_tens = 3'd3; s_ones = 4'd4;
        timer_on = 1'b0; alarm = 1'b0;
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (an !== 4'b1111) $display("FAIL reset_an: got %b want %b", an, 4'b1111); else n_pass++;
        n_checks++;
        if (seg !== SEG_OFF) $display("FAIL reset_seg: got %b want %b", seg, SEG_OFF); else n_pass++;
        n_checks++;
        if (dp !== 1'b1) $display("FAIL reset_dp: got %b want 1", dp); else n_pass++;
        step(2);
        reset = 1'b1;
        for (int c = 1; c < SCAN_DIV; c++) begin
            step(1);
            n_checks++;
            if (an !== 4'b1111) $display("FAIL dark_after_release cyc%0d: got %b want 1111", c, an);
            else n_pass++;
        end
        step(1);
        frame_no = 1;
        for (int d = 0; d < 4; d++) begin
            exp_dp = (d == 2) ? 1'b0 : 1'b1;
            for (int c = 0; c < SCAN_DIV; c++) begin
                n_checks++;
                if (an !== AN_IDX[d] || seg !== exp_seg[d] || dp !== exp_dp)
                    $display("FAIL scan idx%0d cyc%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                             d, c, an, seg, dp, AN_IDX[d], exp_seg[d], exp_dp);
                else n_pass++;
                step(1);
            end
        end
        frame_no = 2;
    endtask

    task automatic test_snapshot();
        n_checks++;
        if (seg !== SEG_4) $display("FAIL snap_idx0_start: got %b want %b", seg, SEG_4); else n_pass++;
        step(1);
        s_ones = 4'd7;
        m_tens = 3'd5;
        step(1);
        n_checks++;
        if (an !== 4'b1110 || seg !== SEG_4)
            $display("FAIL snap_idx0_hold: got an=%b seg=%b want an=1110 seg=%b", an, seg, SEG_4);
        else n_pass++;
        step(2);
        n_checks++;
        if (an !== 4'b1101 || seg !== SEG_3)
            $display("FAIL snap_idx1: got an=%b seg=%b want an=1101 seg=%b", an, seg, SEG_3);
        else n_pass++;
        step(8);
        n_checks++;
        if (an !== 4'b0111 || seg !== SEG_1)
            $display("FAIL snap_idx3_old: got an=%b seg=%b want an=0111 seg=%b", an, seg, SEG_1);
        else n_pass++;
        step(4);
        frame_no = 3;
        n_checks++;
        if (an !== 4'b1110 || seg !== SEG_7)
            $display("FAIL snap_idx0_new: got an=%b seg=%b want an=1110 seg=%b", an, seg, SEG_7);
        else n_pass++;
        step(12);
        n_checks++;
        if (an !== 4'b0111 || seg !== SEG_5)
            $display("FAIL snap_idx3_new: got an=%b seg=%b want an=0111 seg=%b", an, seg, SEG_5);
        else n_pass++;
        step(4);
        frame_no = 4;
    endtask

    task automatic test_alarm();
        logic       exp_dark [6];
        logic [6:0] exp_seg;
        logic       exp_dp;
        exp_dark = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};  // frames 5..10
        m_tens = 3'd0; m_ones = 4'd0; s_tens = 3'd0; s_ones = 4'd0;
        alarm = 1'b1;
        step(4 * SCAN_DIV);
        frame_no = 5;
        for (int f = 0; f < 6; f++) begin
            grab_frame();
            for (int d = 0; d < 4; d++) begin
                n_checks++;
                if (exp_dark[f]) begin
                    if (obs_an[d] !== 4'b1111 || obs_dp[d] !== 1'b1)
                        $display("FAIL alarm_dark frame%0d idx%0d: got an=%b dp=%b want an=1111 dp=1",
                                 f + 5, d, obs_an[d], obs_dp[d]);
                    else n_pass++;
                end else begin
                    exp_seg = (d == 3) ? SEG_MT0 : SEG_0;
                    exp_dp  = (d == 2) ? 1'b0 : 1'b1;
                    if (obs_an[d] !== AN_IDX[d] || obs_seg[d] !== exp_seg || obs_dp[d] !== exp_dp)
                        $display("FAIL alarm_lit frame%0d idx%0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                                 f + 5, d, obs_an[d], obs_seg[d], obs_dp[d], AN_IDX[d], exp_seg, exp_dp);
                    else n_pass++;
                end
            end
        end
        // Frame 11 starts in the dark phase. Clearing alarm mid-digit relights at the next advance.
        n_checks++;
        if (an !== 4'b1111) $display("FAIL alarm_clear_pre: got %b want 1111", an); else n_pass++;
        alarm = 1'b0;
        step(1);
        n_checks++;
        if (an !== 4'b1111) $display("FAIL alarm_clear_hold: got %b want 1111", an); else n_pass++;
        step(SCAN_DIV - 1);
        n_checks++;
        if (an !== 4'b1101 || seg !== SEG_0)
            $display("FAIL alarm_clear_relit: got an=%b seg=%b want an=1101 seg=%b", an, seg, SEG_0);
        else n_pass++;
        step(3 * SCAN_DIV);
        frame_no = 12;
    endtask

    task automatic test_dp_blink();
        logic exp_dp2 [6];
        exp_dp2 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};  // frames 12..17
        timer_on = 1'b1;
        for (int f = 0; f < 6; f++) begin
            if (f == 4) timer_on = 1'b0;
            grab_frame();
            n_checks++;
            if (obs_an[2] !== 4'b1011 || obs_dp[2] !== exp_dp2[f])
                $display("FAIL dp_idx2 frame%0d: got an=%b dp=%b want an=1011 dp=%b",
                         f + 12, obs_an[2], obs_dp[2], exp_dp2[f]);
            else n_pass++;
            n_checks++;
            if (obs_dp[0] !== 1'b1 || obs_dp[1] !== 1'b1 || obs_dp[3] !== 1'b1)
                $display("FAIL dp_other frame%0d: got %b%b%b want 111",
                         f + 12, obs_dp[0], obs_dp[1], obs_dp[3]);
            else n_pass++;
        end
    endtask

    task automatic test_dash();
        logic [6:0] exp_a [4];
        logic [6:0] exp_b [4];
        exp_a = '{SEG_8, SEG_DASH, SEG_9, SEG_MT0};
        exp_b = '{SEG_DASH, SEG_5, SEG_DASH, SEG_DASH};
        m_tens = 3'd0; m_ones = 4'd9; s_tens = 3'd6; s_ones = 4'd8;
        step(4 * SCAN_DIV);
        frame_no = 19;
        grab_frame();
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (obs_an[d] !== AN_IDX[d] || obs_seg[d] !== exp_a[d])
                $display("FAIL dash_a idx%0d: got an=%b seg=%b want an=%b seg=%b",
                         d, obs_an[d], obs_seg[d], AN_IDX[d], exp_a[d]);
            else n_pass++;
        end
        m_tens = 3'd6; m_ones = 4'd15; s_tens = 3'd5; s_ones = 4'd10;
        step(4 * SCAN_DIV);
        frame_no = 21;
        grab_frame();
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (obs_an[d] !== AN_IDX[d] || obs_seg[d] !== exp_b[d])
                $display("FAIL dash_b idx%0d: got an=%b seg=%b want an=%b seg=%b",
                         d, obs_an[d], obs_seg[d], AN_IDX[d], exp_b[d]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        step(SCAN_DIV + 2);
        n_checks++;
        if (an !== 4'b1101) $display("FAIL mid_pre: got %b want 1101", an); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (an !== 4'b1111 || seg !== SEG_OFF || dp !== 1'b1)
            $display("FAIL mid_async: got an=%b seg=%b dp=%b want an=1111 seg=%b dp=1", an, seg, dp, SEG_OFF);
        else n_pass++;
        step(2);
        n_checks++;
        if (an !== 4'b1111) $display("FAIL mid_held: got %b want 1111", an); else n_pass++;
        reset = 1'b1;
        for (int c = 1; c < SCAN_DIV; c++) begin
            step(1);
            n_checks++;
            if (an !== 4'b1111) $display("FAIL mid_release_dark cyc%0d: got %b want 1111", c, an);
            else n_pass++;
        end
        step(1);
        frame_no = 1;
        n_checks++;
        if (an !== 4'b1110 || seg !== SEG_DASH)
            $display("FAIL mid_first_digit: got an=%b seg=%b want an=1110 seg=%b", an, seg, SEG_DASH);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_snapshot();
        test_alarm();
        test_dp_blink();
        test_dash();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
